// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one row at a time, debounces press and release,
// and emits a one-cycle flag with the hex code of each accepted key.
module keypad_scan #(
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 20
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_value,
    output logic       flag
);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);
    localparam logic [7:0] DEB_N      = 8'(DEBOUNCE);

    state_t     state_q, state_d;
    logic [3:0] sync_q, sync_d;
    logic [3:0] col_s_q, col_s_d;
    logic [1:0] row_q, row_d;
    logic [3:0] dwell_q, dwell_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cap_q, cap_d;
    logic       flag_q, flag_d;
    logic [3:0] key_q, key_d;

    function automatic logic one_low(input logic [3:0] pat);
        return (pat == 4'b1110) || (pat == 4'b1101) ||
               (pat == 4'b1011) || (pat == 4'b0111);
    endfunction

    function automatic logic [3:0] map_key(input logic [1:0] row, input logic [3:0] pat);
        logic [1:0] col;
        logic [3:0] code;
        col  = 2'd0;
        code = 4'h0;
        case (pat)
            4'b1101: col = 2'd1;
            4'b1011: col = 2'd2;
            4'b0111: col = 2'd3;
            default: col = 2'd0;
        endcase
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hF;
            4'hD: code = 4'h0;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_comb begin
        sync_d  = col_in;
        col_s_d = sync_q;
        state_d = state_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        flag_d  = 1'b0;
        key_d   = key_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q >= DWELL_LAST) begin
                    if (one_low(col_s_q)) begin
                        cap_d   = col_s_q;
                        cnt_d   = 8'd0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d   = row_q + 2'd1;
                        dwell_d = 4'd0;
                    end
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            ST_DEBOUNCE: begin
                if (col_s_q == cap_q) begin
                    if (cnt_q + 8'd1 >= DEB_N) begin
                        cnt_d   = DEB_N;
                        flag_d  = 1'b1;
                        key_d   = map_key(row_q, cap_q);
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // Bounce: give the same row a fresh dwell before sampling again.
                    state_d = ST_SCAN;
                    dwell_d = 4'd0;
                end
            end
            ST_HELD: begin
                if (col_s_q == 4'b1111) begin
                    cnt_d   = 8'd0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (col_s_q == 4'b1111) begin
                    if (cnt_q + 8'd1 >= DEB_N) begin
                        cnt_d   = 8'd0;
                        row_d   = 2'd0;
                        dwell_d = 4'd0;
                        state_d = ST_SCAN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = 8'd0;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge CLK_1K or negedge RST) begin
        if (!RST) begin
            state_q <= ST_SCAN;
            sync_q  <= 4'b1111;
            col_s_q <= 4'b1111;
            row_q   <= 2'd0;
            dwell_q <= 4'd0;
            cnt_q   <= 8'd0;
            cap_q   <= 4'b1111;
            flag_q  <= 1'b0;
            key_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            col_s_q <= col_s_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            flag_q  <= flag_d;
            key_q   <= key_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign row_out[gi] = (row_q != 2'(gi));
    end

    assign flag      = flag_q;
    assign key_value = key_q;

endmodule
